// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin front end that shares one pipelined multiplier
// between two requesters. A tag pipeline that matches the multiplier latency
// carries each operation's {valid, id} forward, so the product that emerges
// from the multiplier is steered back to the requester that issued it.
module mul_share_arbiter #(
  parameter int unsigned W   = 53,
  parameter int unsigned LAT = 4
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     enable,
  input  logic                     req0Valid,
  input  logic                     req1Valid,
  output logic                     req0Ready,
  output logic                     req1Ready,
  input  logic [W-1:0]             req0A,
  input  logic [W-1:0]             req0B,
  input  logic [W-1:0]             req1A,
  input  logic [W-1:0]             req1B,
  input  logic                     req0Signed,
  input  logic                     req1Signed,
  output logic                     res0Valid,
  output logic                     res1Valid,
  output logic [2*W-1:0]           resData,
  output logic                     mulRun,
  output logic                     mulSigned,
  output logic [W-1:0]             mulA,
  output logic [W-1:0]             mulB,
  input  logic [2*W-1:0]           mulOut,
  output logic [$clog2(LAT+1)-1:0] inFlight
);

  localparam int unsigned INFW = $clog2(LAT+1);

  logic           lastGrant;
  logic           grant0;
  logic           grant1;
  logic           xfer;
  logic           grantId;
  logic [LAT-1:0] tagValid;
  logic [LAT-1:0] tagId;
  logic [INFW-1:0] count;

  // Grant: a lone valid requester wins; a tie goes to the one not served last.
  // Gated by rstN so ready and run read low while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rstN && enable) begin
      if (req0Valid && req1Valid) begin
        grant0 = lastGrant;
        grant1 = ~lastGrant;
      end else begin
        grant0 = req0Valid;
        grant1 = req1Valid;
      end
    end
  end

  assign req0Ready = grant0;
  assign req1Ready = grant1;
  assign xfer      = grant0 | grant1;
  assign grantId   = grant1;

  // Operand mux: the granted requester drives the multiplier, zero when idle.
  always_comb begin
    mulA      = '0;
    mulB      = '0;
    mulSigned = 1'b0;
    if (grant0) begin
      mulA      = req0A;
      mulB      = req0B;
      mulSigned = req0Signed;
    end else if (grant1) begin
      mulA      = req1A;
      mulB      = req1B;
      mulSigned = req1Signed;
    end
  end

  // Remember who was served last; unchanged in cycles without a transfer.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      lastGrant <= 1'b1;
    end else if (xfer) begin
      lastGrant <= grantId;
    end
  end

  // Tag pipeline moves in lockstep with the multiplier, which advances only while run is high.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tagValid <= '0;
      tagId    <= '0;
    end else if (mulRun) begin
      for (int unsigned i = 1; i < LAT; i++) begin
        tagValid[i] <= tagValid[i-1];
        tagId[i]    <= tagId[i-1];
      end
      tagValid[0] <= xfer;
      tagId[0]    <= grantId;
    end
  end

  assign mulRun = xfer | (|tagValid);

  // Result return: last tag stage selects which channel sees the product.
  always_comb begin
    res0Valid = tagValid[LAT-1] & ~tagId[LAT-1];
    res1Valid = tagValid[LAT-1] &  tagId[LAT-1];
    resData   = tagValid[LAT-1] ? mulOut : '0;
  end

  // Occupancy: number of valid tag stages.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < LAT; i++) begin
      count = count + INFW'(tagValid[i]);
    end
  end

  assign inFlight = count;

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Shares one pipelined 53-bit radix-4 Booth/Wallace multiplier between two requesters. Round-robin arbitration with valid/ready handshakes on the request side, free-running result return, and a tag pipeline matched to the multiplier latency that routes each product back to its issuer. Sits between the FPU mantissa path (requester 0) and the integer MUL unit (requester 1) and the shared multiplier instance.

## Interface
- `W`, 53, operand width; product is `2*W`
- `LAT`, 4, multiplier latency in clock edges from operand presentation to valid `mulOut`; legal range 1..8
- `clk`  in  1  clock, rising-edge active
- `rstN`  in  1  reset, asynchronous and active-low
- `enable`  in  1  issue enable; low blocks new grants, in-flight ops drain
- `req0Valid`, `req1Valid`  in  1  request present
- `req0Ready`, `req1Ready`  out  1  request accepted this cycle (combinational)
- `req0A`, `req0B`, `req1A`, `req1B`  in  W  multiplicand / multiplier
- `req0Signed`, `req1Signed`  in  1  1 = two's-complement operands
- `res0Valid`, `res1Valid`  out  1  product for that requester valid this cycle
- `resData`  out  2W  product, shared by both result channels
- `mulRun`  out  1  multiplier `run`
- `mulSigned`  out  1  multiplier `signedFlag`
- `mulA`, `mulB`  out  W  multiplier operands
- `mulOut`  in  2W  multiplier product
- `inFlight`  out  $clog2(LAT+1)  ops issued, result not yet returned

## Operation
- Handshake: transfer on requester n when `reqNValid && reqNReady`; at most one transfer per cycle. Ready never asserts without valid.
- Arbitration, `enable`=1: single valid requester granted immediately; both valid → grant the one not in `lastGrant`; `lastGrant` updates on every transfer. `enable`=0: both ready low.
- Issue is same-cycle: `mulA/mulB/mulSigned` are a combinational mux of the granted requester's inputs; when no grant, they hold 0.
- Tag pipeline: LAT-deep shift register of {valid, id}. Stage 0 loads {transfer, grantId} each edge; shifts unconditionally every edge while `mulRun`=1.
- `mulRun` = transfer this cycle OR any tag stage valid. Multiplier idles with run low only when nothing in flight.
- Result: when last tag stage valid, `resData` = `mulOut` and `res<id>Valid`=1 for exactly one cycle; no backpressure — requesters must accept. `resData` = 0 when neither result valid.
- `inFlight` = count of valid tag stages; max LAT (full throughput, one op/cycle).
- Reset values: `req0Ready`=`req1Ready`=0, `res0Valid`=`res1Valid`=0, `resData`=0, `mulRun`=0, `inFlight`=0, all tag stages invalid, `lastGrant`=1 (requester 0 wins first tie).

## Timing
- Transfer in cycle t → `resNValid` high in cycle t+LAT, aligned with `mulOut` for those operands.
- Back-to-back transfers each cycle → results each cycle, order preserved, ids preserved.
- Tie every cycle → strict alternation 0,1,0,1…
- `enable` falling with ops in flight: no new transfers from that cycle; remaining results still emerge on schedule; `mulRun` drops the cycle after the last tag leaves the pipe.
- Requester dropping valid in a cycle where it would win: other requester granted same cycle if valid; `lastGrant` unchanged when no transfer.
- `rstN` low mid-operation: all outputs to reset values immediately (asynchronous); in-flight results discarded, never reported after release. First transfer permitted in the first cycle after `rstN` rises.

## Test plan
- Single op, requester 0, unsigned 3×5 → `res0Valid` exactly at t+4, `resData`=15, `res1Valid` never high, `inFlight` 1→0.
- Both valid for 8 cycles, req0 A=i, req1 A=i+100, B=2 → grants 0,1,0,1…, eight results at t+4..t+11 with matching ids and products.
- Signed: req1Signed=1, A=all-ones (−1), B=3 → `resData`=−3 in 106-bit two's complement; same operands unsigned from req0 → (2^53−1)·3.
- Boundary: A=B=2^53−1 unsigned → `resData`=2^106−2^54+1.
- `enable` low two cycles after 2 issues → both ready 0, 2 results still delivered, `mulRun` 0 after last, `inFlight`=0.
- `rstN` pulsed low with 3 ops in flight → all outputs 0 during reset, no `resNValid` afterwards, next tie granted to requester 0.
